// File: rtl/addsub_quat.sv
// Quaternion add/subtract: four independent FP16 adder lanes sharing one add/sub
// select, with a single registered output stage.

module fp16_add (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_sub,
  output logic [15:0] o_y
);

  logic [15:0] w_b, w_lg, w_sm;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_eff_sub, w_sl, w_ss, w_inc;
  logic [5:0]  w_el, w_es, w_d, w_en, w_sh, w_ex;
  logic [10:0] w_ml, w_ms;
  logic [39:0] w_wide;
  logic [13:0] w_lm, w_sa, w_m;
  logic [14:0] w_sum;
  logic [3:0]  w_lz;
  logic [11:0] w_rnd;
  logic [9:0]  w_fr;

  // Leading-zero count of the 14-bit working mantissa; bit 13 is the hidden-one slot.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    lzc14 = 4'd14;
    for (int n = 0; n < 14; n++)
      if (v[n]) lzc14 = 4'(13 - n);
  endfunction

  always_comb begin
    w_b       = {i_b[15] ^ i_sub, i_b[14:0]};
    w_a_nan   = (&i_a[14:10]) & (|i_a[9:0]);
    w_b_nan   = (&w_b[14:10]) & (|w_b[9:0]);
    w_a_inf   = (&i_a[14:10]) & ~(|i_a[9:0]);
    w_b_inf   = (&w_b[14:10]) & ~(|w_b[9:0]);
    // Order operands by magnitude so the subtraction never goes negative.
    if (w_b[14:0] > i_a[14:0]) begin
      w_lg = w_b; w_sm = i_a;
    end else begin
      w_lg = i_a; w_sm = w_b;
    end
    w_sl      = w_lg[15];
    w_ss      = w_sm[15];
    w_eff_sub = w_sl ^ w_ss;
    w_el      = (w_lg[14:10] == 5'd0) ? 6'd1 : {1'b0, w_lg[14:10]};
    w_es      = (w_sm[14:10] == 5'd0) ? 6'd1 : {1'b0, w_sm[14:10]};
    w_ml      = {(w_lg[14:10] != 5'd0), w_lg[9:0]};
    w_ms      = {(w_sm[14:10] != 5'd0), w_sm[9:0]};
    w_d       = w_el - w_es;
    // Mantissa + guard/round + sticky; the wide shift keeps every bit for the sticky OR.
    w_lm      = {w_ml, 3'b000};
    w_wide    = {w_ms, 29'd0} >> w_d;
    w_sa      = {w_wide[39:27], |w_wide[26:0]};
    w_sum     = w_eff_sub ? ({1'b0, w_lm} - {1'b0, w_sa}) : ({1'b0, w_lm} + {1'b0, w_sa});
    w_lz      = 4'd0;
    w_sh      = 6'd0;
    if (w_sum[14]) begin
      w_m  = {w_sum[14:2], w_sum[1] | w_sum[0]};
      w_en = w_el + 6'd1;
    end else begin
      // Left shift is capped so the exponent bottoms out at 1 (subnormal result).
      w_lz = lzc14(w_sum[13:0]);
      w_sh = ({2'b00, w_lz} > (w_el - 6'd1)) ? (w_el - 6'd1) : {2'b00, w_lz};
      w_m  = w_sum[13:0] << w_sh;
      w_en = w_el - w_sh;
    end
    w_inc = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_rnd = {1'b0, w_m[13:3]} + {11'd0, w_inc};
    if (w_rnd[11]) begin
      w_ex = w_en + 6'd1;
      w_fr = 10'd0;
    end else begin
      w_ex = w_rnd[10] ? w_en : 6'd0;
      w_fr = w_rnd[9:0];
    end

    if (w_ex >= 6'd31) o_y = {w_sl, 5'h1F, 10'd0};
    else               o_y = {w_sl, w_ex[4:0], w_fr};
    if (w_sum == 15'd0) o_y = {w_sl & w_ss, 15'd0};

    if (w_a_nan | w_b_nan)       o_y = 16'h7E00;
    else if (w_a_inf & w_b_inf)  o_y = (i_a[15] ^ w_b[15]) ? 16'h7E00 : i_a;
    else if (w_a_inf)            o_y = i_a;
    else if (w_b_inf)            o_y = w_b;
  end

endmodule

module addsub_quat (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] w_in1,
  input  logic [15:0] i_in1,
  input  logic [15:0] j_in1,
  input  logic [15:0] k_in1,
  input  logic [15:0] w_in2,
  input  logic [15:0] i_in2,
  input  logic [15:0] j_in2,
  input  logic [15:0] k_in2,
  input  logic        select,
  output logic [15:0] w_out,
  output logic [15:0] i_out,
  output logic [15:0] j_out,
  output logic [15:0] k_out
);

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 16;

  logic [NUM_LANES-1:0][VEC_W-1:0] w_a, w_b, w_y, r_y;

  assign w_a = {k_in1, j_in1, i_in1, w_in1};
  assign w_b = {k_in2, j_in2, i_in2, w_in2};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fp16_add u_lane (
      .i_a   (w_a[l]),
      .i_b   (w_b[l]),
      .i_sub (select),
      .o_y   (w_y[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_y <= '0;
    else        r_y <= w_y;
  end

  assign w_out = r_y[0];
  assign i_out = r_y[1];
  assign j_out = r_y[2];
  assign k_out = r_y[3];

endmodule

// File: tb/tb_addsub_quat.sv
// Directed vector bench for addsub_quat: lanes ordered {k,j,i,w}.

module tb_addsub_quat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] w_in1, i_in1, j_in1, k_in1, w_in2, i_in2, j_in2, k_in2;
  logic        select;
  logic [15:0] w_out, i_out, j_out, k_out;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic             sel;
    logic [3:0][15:0] y;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  addsub_quat dut (
    .clk(clk), .rst_n(rst_n),
    .w_in1(w_in1), .i_in1(i_in1), .j_in1(j_in1), .k_in1(k_in1),
    .w_in2(w_in2), .i_in2(i_in2), .j_in2(j_in2), .k_in2(k_in2),
    .select(select),
    .w_out(w_out), .i_out(i_out), .j_out(j_out), .k_out(k_out)
  );

  task automatic drive(input vec_t v);
    {k_in1, j_in1, i_in1, w_in1} = v.a;
    {k_in2, j_in2, i_in2, w_in2} = v.b;
    select = v.sel;
  endtask

  task automatic check(input string name, input logic [3:0][15:0] exp);
    logic [3:0][15:0] act;
    act = {k_out, j_out, i_out, w_out};
    for (int l = 0; l < 4; l++) begin
      n_chk++;
      if (act[l] !== exp[l]) begin
        n_fail++;
        $display("FAIL %s lane%0d: got %h expected %h", name, l, act[l], exp[l]);
      end
    end
  endtask

  initial begin
    //            a {k,j,i,w}                          b {k,j,i,w}                          sel   y {k,j,i,w}
    vecs[0] = '{{16'h3219,16'h3219,16'h3219,16'h3219}, {16'h3219,16'h3219,16'h3219,16'h3219}, 1'b0, {16'h3619,16'h3619,16'h3619,16'h3619}};
    vecs[1] = '{{16'h3219,16'h3219,16'h3219,16'h3219}, {16'h3219,16'h3219,16'h3219,16'h3219}, 1'b1, {16'h0000,16'h0000,16'h0000,16'h0000}};
    vecs[2] = '{{16'h3C01,16'h3C00,16'h0001,16'h3C00}, {16'h1000,16'h1000,16'h0001,16'h4000}, 1'b0, {16'h3C02,16'h3C00,16'h0002,16'h4200}};
    vecs[3] = '{{16'h3C01,16'h3C00,16'h0001,16'h3C00}, {16'h1000,16'h1000,16'h0001,16'h4000}, 1'b1, {16'h3C00,16'h3BFF,16'h0000,16'hBC00}};
    vecs[4] = '{{16'h8000,16'h7C00,16'h7E01,16'h7BFF}, {16'h8000,16'h7C00,16'h3C00,16'h7BFF}, 1'b0, {16'h8000,16'h7C00,16'h7E00,16'h7C00}};
    vecs[5] = '{{16'h7C00,16'hFBFF,16'h8000,16'h7C00}, {16'h3C00,16'h7BFF,16'h0000,16'h7C00}, 1'b1, {16'h7C00,16'hFC00,16'h8000,16'h7E00}};
    vecs[6] = '{{16'h0000,16'hFC00,16'h3C00,16'h03FF}, {16'h8000,16'h7C00,16'hBC00,16'h0001}, 1'b0, {16'h0000,16'h7E00,16'h0000,16'h0400}};
    vecs[7] = '{{16'h0400,16'h8001,16'h4248,16'h4000}, {16'h8001,16'h0001,16'h4248,16'h0001}, 1'b0, {16'h03FF,16'h0000,16'h4648,16'h4000}};

    drive(vecs[0]);
    #1 check("reset_state", '0);
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      @(negedge clk) drive(vecs[v]);
      @(posedge clk) #1 check($sformatf("vec%0d", v), vecs[v].y);
    end

    // Async reset between edges, then recovery on the first edge after release.
    @(posedge clk) #2 rst_n = 1'b0;
    #1 check("async_reset", '0);
    @(posedge clk) #1 check("reset_held", '0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("released_no_edge", '0);
    @(posedge clk) #1 check("after_release", vecs[7].y);

    @(negedge clk) drive(vecs[2]);
    @(posedge clk) #1 check("back_to_back", vecs[2].y);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
